// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch stage controller for a variable-latency
// instruction memory with a request/valid handshake.
//
// Owns the fetch PC, keeps at most one memory request outstanding, registers
// returned words into the F/D pipeline registers, parks a word in a one-entry
// hold buffer while decode stalls, and applies Execute redirects while
// discarding any response made stale by them.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   stall_d      in   decode cannot accept; hold the D outputs
//   pc_src_e     in   redirect request from Execute
//   pc_target_e  in   redirect target
//   imem_req     out  request strobe (combinational), accepted same cycle
//   imem_addr    out  request address (combinational), valid with imem_req
//   imem_rvalid  in   response valid, at least one cycle after the request
//   imem_rdata   in   response word
//   instr_d      out  F/D instruction
//   pc_d         out  F/D PC
//   pc_plus4_d   out  F/D PC+4
//   valid_d      out  F/D holds a real instruction (0 = bubble)
//   timeout      out  one-cycle pulse when the memory fails to answer in time
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        timeout
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // What happens to the F/D registers this cycle.
    typedef enum logic [1:0] {
        D_KEEP   = 2'd0,
        D_MEM    = 2'd1,
        D_HOLD   = 2'd2,
        D_BUBBLE = 2'd3
    } d_op_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // r_pc_f always tracks the address of the request that is (or will next be)
    // outstanding, so a returning word is always paired with r_pc_f.
    logic [XLEN-1:0]   r_pc_f;
    logic [XLEN-1:0]   w_pc_f_nxt;
    logic [XLEN-1:0]   w_pc_f_inc;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_wait_expire;

    logic [XLEN-1:0]   r_hold_instr;
    logic [XLEN-1:0]   r_hold_pc;
    logic              w_hold_wr;

    logic [XLEN-1:0]   r_instr_d;
    logic [XLEN-1:0]   r_pc_d;
    logic [XLEN-1:0]   r_pc_plus4_d;
    logic              r_valid_d;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic              w_accept;
    logic              w_req;
    logic [XLEN-1:0]   w_addr;
    d_op_t             w_d_op;

    assign w_accept      = !r_valid_d || !stall_d;
    assign w_pc_f_inc    = r_pc_f + PC_STEP;
    assign w_wait_expire = (r_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, request strobe and datapath controls.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_f_nxt    = r_pc_f;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        w_req         = 1'b0;
        w_addr        = r_pc_f;
        w_d_op        = D_KEEP;
        w_hold_wr     = 1'b0;

        if (pc_src_e) begin
            // Redirect flushes D regardless of stall and discards any held word.
            w_d_op     = D_BUBBLE;
            w_pc_f_nxt = pc_target_e;
            w_addr     = pc_target_e;
            if ((r_state == S_WAIT || r_state == S_DROP) && !imem_rvalid) begin
                // Old request still in flight: wait it out in DROP.
                if (w_wait_expire) begin
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_state_nxt = S_DROP;
                end
            end else begin
                // Nothing in flight after this edge: fetch the target now.
                w_req       = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_req       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                    if (w_accept) begin
                        w_d_op = D_BUBBLE;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_pc_f_nxt = w_pc_f_inc;
                        if (w_accept) begin
                            // Deliver and immediately fetch the next word.
                            w_d_op    = D_MEM;
                            w_req     = 1'b1;
                            w_addr    = w_pc_f_inc;
                            w_cnt_nxt = '0;
                        end else begin
                            w_hold_wr   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end else begin
                        if (w_accept) begin
                            w_d_op = D_BUBBLE;
                        end
                        if (w_wait_expire) begin
                            w_timeout_nxt = 1'b1;
                            w_cnt_nxt     = '0;
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_d) begin
                        w_d_op      = D_HOLD;
                        w_req       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        // Stale word arrives and is dropped; fetch the real PC.
                        w_req       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end else begin
                        if (w_accept) begin
                            w_d_op = D_BUBBLE;
                        end
                        if (w_wait_expire) begin
                            w_timeout_nxt = 1'b1;
                            w_cnt_nxt     = '0;
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Fetch PC, wait counter, hold buffer and F/D registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_f       <= RESET_PC;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            r_pc_f    <= w_pc_f_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_hold_wr) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= r_pc_f;
            end
            case (w_d_op)
                D_MEM: begin
                    r_instr_d    <= imem_rdata;
                    r_pc_d       <= r_pc_f;
                    r_pc_plus4_d <= w_pc_f_inc;
                    r_valid_d    <= 1'b1;
                end
                D_HOLD: begin
                    r_instr_d    <= r_hold_instr;
                    r_pc_d       <= r_hold_pc;
                    r_pc_plus4_d <= r_hold_pc + PC_STEP;
                    r_valid_d    <= 1'b1;
                end
                D_BUBBLE: begin
                    r_valid_d <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Request outputs are forced low while reset is asserted.
    assign imem_req   = rst & w_req;
    assign imem_addr  = rst ? w_addr : '0;

    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a latency-programmable memory model
// feeds a scoreboard of expected F/D deliveries; scenario tasks check request
// addresses, bubbles, stall holding, redirects, wrap, timeout and reset.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        stall_d     = 1'b0;
    logic        pc_src_e    = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        timeout;

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_d     (stall_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] plus4;
    } exp_t;

    int          n_vec       = 0;
    int          n_err       = 0;
    exp_t        sb[$];
    logic [31:0] req_log[$];
    int          latency     = 1;
    bit          mute        = 1'b0;
    bit          busy        = 1'b0;
    bit          resp_stale  = 1'b0;
    logic [31:0] resp_addr   = '0;
    int          wait_left   = 0;
    bit          prev_accept = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Bus observer at the active edge: tracks the outstanding request, marks
    // responses stale on redirect and pushes expected deliveries.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            busy        = 1'b0;
            prev_accept = 1'b0;
            sb.delete();
        end else begin
            prev_accept = !valid_d || !stall_d;
            if (pc_src_e) sb.delete();
            if (busy && imem_rvalid) begin
                if (!pc_src_e && !resp_stale) begin
                    exp_t e;
                    e.instr = mem_word(resp_addr);
                    e.pc    = resp_addr;
                    e.plus4 = resp_addr + 32'd4;
                    sb.push_back(e);
                end
                busy = 1'b0;
            end else if (busy && pc_src_e) begin
                resp_stale = 1'b1;
            end
            if (imem_req) begin
                n_vec++;
                if (busy) begin
                    n_err++;
                    $display("FAIL one_outstanding: got imem_req=1 addr=%h, expected no request while %h pending",
                             imem_addr, resp_addr);
                end
                req_log.push_back(imem_addr);
                if (!mute) begin
                    busy       = 1'b1;
                    resp_stale = 1'b0;
                    resp_addr  = imem_addr;
                    wait_left  = latency;
                end
            end
        end
    end

    // Memory responder: raises imem_rvalid 'latency' edges after the request.
    initial forever begin
        @(negedge clk);
        if (rst && busy) begin
            if (wait_left > 1) begin
                wait_left--;
                imem_rvalid = 1'b0;
            end else begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(resp_addr);
            end
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    // Delivery monitor: a new F/D word is valid_d=1 after a cycle that accepted.
    initial forever begin
        @(negedge clk);
        if (rst && valid_d && prev_accept) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL deliver_unexpected: got pc_d=%h instr_d=%h, expected no new instruction",
                         pc_d, instr_d);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({instr_d, pc_d, pc_plus4_d} !== e) begin
                    n_err++;
                    $display("FAIL deliver: got instr=%h pc=%h pc4=%h, expected instr=%h pc=%h pc4=%h",
                             instr_d, pc_d, pc_plus4_d, e.instr, e.pc, e.plus4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = valid_d;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL %s: got valid_d=0 for 20 cycles, expected a delivery", name);
        end
    endtask

    task automatic wait_deliv(input logic [31:0] pc, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = valid_d && (pc_d === pc);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL %s: got valid_d=%b pc_d=%h after 30 cycles, expected pc_d=%h", name, valid_d, pc_d, pc);
        end
    endtask

    task automatic check_last_req(input logic [31:0] addr, input string name);
        logic [31:0] got;
        got = (req_log.size() > 0) ? req_log[req_log.size()-1] : 32'hxxxx_xxxx;
        n_vec++;
        if (got !== addr) begin
            n_err++;
            $display("FAIL %s: got last request %h, expected %h", name, got, addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_vec++;
        if ({imem_req, valid_d, timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got req=%b valid=%b timeout=%b, expected 0 0 0", imem_req, valid_d, timeout);
        end
        n_vec++;
        if ({imem_addr, instr_d, pc_d, pc_plus4_d} !== 128'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h instr=%h pc=%h pc4=%h, expected all 0",
                     imem_addr, instr_d, pc_d, pc_plus4_d);
        end
        req_log.delete();
        rst = 1'b1;
        step();
        check_last_req(RESET_PC, "reset_first_req");
    endtask

    task automatic test_latency1();
        int ones = 0;
        wait_valid("lat1_first");
        n_vec++;
        if ({instr_d, pc_d, pc_plus4_d} !== {mem_word(32'h0), 32'h0, 32'h4}) begin
            n_err++;
            $display("FAIL lat1_d0: got instr=%h pc=%h pc4=%h, expected %h 0 4", instr_d, pc_d, pc_plus4_d, mem_word(32'h0));
        end
        step();
        n_vec++;
        if ({pc_d, pc_plus4_d} !== {32'h4, 32'h8}) begin
            n_err++;
            $display("FAIL lat1_d1: got pc=%h pc4=%h, expected 4 8", pc_d, pc_plus4_d);
        end
        n_vec++;
        if (req_log.size() < 3 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
            n_err++;
            $display("FAIL lat1_addr_seq: got %0d requests, expected 0,4,8 in order", req_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            step();
            ones += int'(valid_d);
        end
        n_vec++;
        if (ones != 4) begin
            n_err++;
            $display("FAIL lat1_stream: got valid_d high %0d of 4 cycles, expected 4", ones);
        end
    endtask

    task automatic test_latency3();
        int ones = 0;
        latency = 3;
        repeat (6) step();
        for (int i = 0; i < 9; i++) begin
            step();
            ones += int'(valid_d);
        end
        n_vec++;
        if (ones != 3) begin
            n_err++;
            $display("FAIL lat3_bubbles: got valid_d high %0d of 9 cycles, expected 3", ones);
        end
    endtask

    task automatic test_stall();
        logic [31:0] s_instr;
        logic [31:0] s_pc;
        int          n_req;
        latency = 2;
        repeat (4) step();
        wait_valid("stall_sync");
        s_instr = instr_d;
        s_pc    = pc_d;
        n_req   = req_log.size();
        stall_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if ({valid_d, instr_d, pc_d} !== {1'b1, s_instr, s_pc}) begin
                n_err++;
                $display("FAIL stall_hold: got valid=%b instr=%h pc=%h, expected 1 %h %h",
                         valid_d, instr_d, pc_d, s_instr, s_pc);
            end
        end
        n_vec++;
        if (req_log.size() != n_req) begin
            n_err++;
            $display("FAIL stall_no_req: got %0d requests during stall, expected 0", req_log.size() - n_req);
        end
        stall_d = 1'b0;
        step();
        n_vec++;
        if ({valid_d, pc_d, pc_plus4_d} !== {1'b1, s_pc + 32'd4, s_pc + 32'd8}) begin
            n_err++;
            $display("FAIL stall_release: got valid=%b pc=%h pc4=%h, expected 1 %h %h",
                     valid_d, pc_d, pc_plus4_d, s_pc + 32'd4, s_pc + 32'd8);
        end
        check_last_req(s_pc + 32'd8, "stall_next_req");
    endtask

    task automatic test_redirect();
        int n_req;
        latency = 2;
        repeat (4) step();
        wait_valid("redir_sync");
        n_req       = req_log.size();
        pc_src_e    = 1'b1;
        pc_target_e = 32'h0000_0100;
        step();
        pc_src_e = 1'b0;
        n_vec++;
        if (valid_d !== 1'b0 || req_log.size() != n_req) begin
            n_err++;
            $display("FAIL redir_drop: got valid=%b new_reqs=%0d, expected 0 0", valid_d, req_log.size() - n_req);
        end
        step();
        check_last_req(32'h0000_0100, "redir_target_req");
        n_vec++;
        if (valid_d !== 1'b0) begin
            n_err++;
            $display("FAIL redir_stale: got valid_d=%b pc_d=%h, expected stale word suppressed", valid_d, pc_d);
        end
        wait_deliv(32'h0000_0100, "redir_deliver");
    endtask

    task automatic test_flush_stall();
        repeat (2) step();
        wait_valid("flush_sync");
        stall_d     = 1'b1;
        pc_src_e    = 1'b1;
        pc_target_e = 32'h0000_0200;
        step();
        n_vec++;
        if (valid_d !== 1'b0) begin
            n_err++;
            $display("FAIL flush_over_stall: got valid_d=%b, expected 0", valid_d);
        end
        stall_d  = 1'b0;
        pc_src_e = 1'b0;
        wait_deliv(32'h0000_0200, "flush_deliver");
    endtask

    task automatic test_wrap();
        latency = 1;
        repeat (4) step();
        pc_src_e    = 1'b1;
        pc_target_e = 32'hFFFF_FFFC;
        step();
        pc_src_e = 1'b0;
        check_last_req(32'hFFFF_FFFC, "wrap_req");
        step();
        n_vec++;
        if ({valid_d, pc_d, pc_plus4_d} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            n_err++;
            $display("FAIL wrap_d: got valid=%b pc=%h pc4=%h, expected 1 fffffffc 00000000", valid_d, pc_d, pc_plus4_d);
        end
        check_last_req(32'h0000_0000, "wrap_next_req");
        step();
        pc_src_e    = 1'b1;
        pc_target_e = 32'h0000_0102;
        step();
        pc_src_e = 1'b0;
        check_last_req(32'h0000_0102, "lowbits_req");
        step();
        n_vec++;
        if ({pc_d, pc_plus4_d} !== {32'h102, 32'h106}) begin
            n_err++;
            $display("FAIL lowbits_d: got pc=%h pc4=%h, expected 102 106", pc_d, pc_plus4_d);
        end
        check_last_req(32'h0000_0106, "lowbits_next_req");
    endtask

    task automatic test_timeout_reset();
        logic [6:0] to_seen;
        repeat (3) step();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({imem_req, valid_d, timeout, imem_addr, instr_d, pc_d, pc_plus4_d} !== 131'd0) begin
            n_err++;
            $display("FAIL reset_mid_wait: got req=%b valid=%b addr=%h instr=%h pc=%h pc4=%h, expected all 0",
                     imem_req, valid_d, imem_addr, instr_d, pc_d, pc_plus4_d);
        end
        mute = 1'b1;
        step();
        step();
        req_log.delete();
        rst = 1'b1;
        to_seen = '0;
        for (int i = 1; i <= 6; i++) begin
            step();
            to_seen[i] = timeout;
        end
        n_vec++;
        if (to_seen !== 7'b010_0000) begin
            n_err++;
            $display("FAIL timeout_pulse: got timeout history %b (cycles 6..1), expected 0100000", to_seen[6:1]);
        end
        n_vec++;
        if (req_log.size() != 2 || req_log[0] !== RESET_PC || req_log[1] !== RESET_PC) begin
            n_err++;
            $display("FAIL timeout_reissue: got %0d requests, expected 2 to %h", req_log.size(), RESET_PC);
        end
        mute = 1'b0;
        wait_deliv(RESET_PC, "timeout_recover");
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d undelivered entries, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency1();
        test_latency3();
        test_stall();
        test_redirect();
        test_flush_stall();
        test_wrap();
        test_timeout_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
